// File: rtl/pio_fifo.sv
// Per-state-machine TX/RX word FIFO pair sharing one 2*DEPTH storage array.
// Either direction can borrow the other's half (join), leaving the other with zero capacity.
module pio_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH) + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             join_tx,
  input  logic             join_rx,
  input  logic             flush,
  input  logic             err_clr,
  input  logic             bus_tx_we,
  input  logic [WIDTH-1:0] bus_tx_wdata,
  output logic [WIDTH-1:0] sm_tx_rdata,
  output logic             sm_tx_rvalid,
  input  logic             sm_tx_rready,
  input  logic [WIDTH-1:0] sm_rx_wdata,
  input  logic             sm_rx_wvalid,
  output logic             sm_rx_wready,
  input  logic             bus_rx_re,
  output logic [WIDTH-1:0] bus_rx_rdata,
  output logic             bus_rx_rvalid,
  output logic [LW-1:0]    tx_level,
  output logic [LW-1:0]    rx_level,
  output logic             tx_full,
  output logic             tx_empty,
  output logic             rx_full,
  output logic             rx_empty,
  output logic             tx_overflow,
  output logic             rx_underflow
);

  localparam int PW = LW - 1;

  typedef enum logic [1:0] {
    MODE_SPLIT   = 2'd0,
    MODE_JOIN_TX = 2'd1,
    MODE_JOIN_RX = 2'd2
  } mode_e;

  mode_e            mode_q;
  mode_e            mode_req;
  logic [WIDTH-1:0] mem [2*DEPTH];

  logic [PW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [PW-1:0] tx_base, rx_base;
  logic [PW-1:0] tx_wr_idx, tx_rd_idx, rx_wr_idx, rx_rd_idx;
  logic [LW-1:0] tx_cap, rx_cap;

  logic flush_all;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic tx_ovf_evt, rx_und_evt;

  // Advance a pointer, wrapping at the capacity of the current mode.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p, input logic [LW-1:0] cap);
    logic [LW-1:0] n;
    n = {1'b0, p} + LW'(1);
    return (n >= cap) ? '0 : n[PW-1:0];
  endfunction

  always_comb begin
    mode_req = MODE_SPLIT;
    if (join_tx && !join_rx) begin
      mode_req = MODE_JOIN_TX;
    end else if (join_rx && !join_tx) begin
      mode_req = MODE_JOIN_RX;
    end
  end

  always_comb begin
    tx_cap  = LW'(DEPTH);
    rx_cap  = LW'(DEPTH);
    tx_base = '0;
    rx_base = PW'(DEPTH);
    case (mode_q)
      MODE_JOIN_TX: begin
        tx_cap = LW'(2 * DEPTH);
        rx_cap = '0;
      end
      MODE_JOIN_RX: begin
        tx_cap  = '0;
        rx_cap  = LW'(2 * DEPTH);
        rx_base = '0;
      end
      default: ;
    endcase
  end

  // A zero-capacity direction reads as both full and empty.
  assign tx_full       = (tx_level == tx_cap);
  assign tx_empty      = (tx_level == '0);
  assign rx_full       = (rx_level == rx_cap);
  assign rx_empty      = (rx_level == '0);
  assign sm_tx_rvalid  = !tx_empty;
  assign bus_rx_rvalid = !rx_empty;
  assign sm_rx_wready  = !rx_full;

  assign flush_all  = flush || (mode_req != mode_q);
  assign tx_push    = bus_tx_we && !tx_full;
  assign tx_pop     = sm_tx_rvalid && sm_tx_rready;
  assign rx_push    = sm_rx_wvalid && sm_rx_wready;
  assign rx_pop     = bus_rx_re && !rx_empty;
  assign tx_ovf_evt = bus_tx_we && tx_full;
  assign rx_und_evt = bus_rx_re && rx_empty;

  assign tx_wr_idx = tx_base + tx_wr_ptr;
  assign tx_rd_idx = tx_base + tx_rd_ptr;
  assign rx_wr_idx = rx_base + rx_wr_ptr;
  assign rx_rd_idx = rx_base + rx_rd_ptr;

  assign sm_tx_rdata  = mem[tx_rd_idx];
  assign bus_rx_rdata = rx_empty ? '0 : mem[rx_rd_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q    <= MODE_SPLIT;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      tx_level  <= '0;
      rx_level  <= '0;
    end else if (flush_all) begin
      mode_q    <= mode_req;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      tx_level  <= '0;
      rx_level  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= bump(tx_wr_ptr, tx_cap);
      if (tx_pop)  tx_rd_ptr <= bump(tx_rd_ptr, tx_cap);
      if (rx_push) rx_wr_ptr <= bump(rx_wr_ptr, rx_cap);
      if (rx_pop)  rx_rd_ptr <= bump(rx_rd_ptr, rx_cap);
      case ({tx_push, tx_pop})
        2'b10:   tx_level <= tx_level + LW'(1);
        2'b01:   tx_level <= tx_level - LW'(1);
        default: ;
      endcase
      case ({rx_push, rx_pop})
        2'b10:   rx_level <= rx_level + LW'(1);
        2'b01:   rx_level <= rx_level - LW'(1);
        default: ;
      endcase
    end
  end

  // Error events take precedence over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      if (tx_ovf_evt)   tx_overflow <= 1'b1;
      else if (err_clr) tx_overflow <= 1'b0;
      if (rx_und_evt)   rx_underflow <= 1'b1;
      else if (err_clr) rx_underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush_all) begin
      if (tx_push) mem[tx_wr_idx] <= bus_tx_wdata;
      if (rx_push) mem[rx_wr_idx] <= sm_rx_wdata;
    end
  end

endmodule
